seq_stream_checker: RTL and testbench

SEQ_STREAM_CHECKER -- requirements
Module: seq_stream_checker

---
 rtl/seq_stream_checker.sv | 123 ++++++++++++
 tb/tb_seq_stream_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_checker.sv
// Stream checker for an incrementing-counter source. Throttles the upstream
// with a ready FSM. Checks that each accepted beat is the previous beat + 1.
// Also watches the upstream for valid/ready protocol violations.
module seq_stream_checker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DELAY_CHK  = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  up_ready,
  output logic [CNT_WIDTH-1:0]  rx_cnt,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic                  proto_err
);

  // The wait counter only ever holds DELAY_CHK-1 down to 0.
  localparam int unsigned WAIT_W = (DELAY_CHK > 1) ? $clog2(DELAY_CHK) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    WAIT_W'((DELAY_CHK > 0) ? (DELAY_CHK - 1) : 0);

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic [DATA_WIDTH-1:0] expected;
  logic                  stall_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  hs;
  logic                  mismatch;

  assign hs       = up_valid & up_ready;
  assign mismatch = (up_data != expected);

  // Ready FSM state register; reset parks it in WAIT with the counter at 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= ST_WAIT;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic: count out the idle gap, then offer ready again.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = ST_READY;
        end else begin
          wait_cnt_nxt = wait_cnt - WAIT_W'(1);
        end
      end
      ST_READY: begin
        if (hs && (DELAY_CHK > 0)) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = WAIT_LOAD;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  // Output decode: ready is asserted exactly while in READY.
  always_comb begin
    up_ready = (state == ST_READY);
  end

  // Sequence check, counters, first-error capture and protocol monitor.
  always_ff @(posedge clk) begin
    if (rst) begin
      expected       <= '0;
      rx_cnt         <= '0;
      err            <= 1'b0;
      err_cnt        <= '0;
      first_err_data <= '0;
      first_err_exp  <= '0;
      proto_err      <= 1'b0;
      stall_q        <= 1'b0;
      data_q         <= '0;
    end else begin
      if (hs) begin
        // Resync on every beat so a single discontinuity counts only once.
        expected <= up_data + DATA_WIDTH'(1);
        rx_cnt   <= rx_cnt + CNT_WIDTH'(1);
        if (mismatch) begin
          err <= 1'b1;
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + CNT_WIDTH'(1);
          end
          if (!err) begin
            first_err_data <= up_data;
            first_err_exp  <= expected;
          end
        end
      end
      // A stalled beat must stay valid with unchanged payload.
      stall_q <= up_valid & ~up_ready;
      data_q  <= up_data;
      if (stall_q && (!up_valid || (up_data != data_q))) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_stream_checker.sv
// Directed bench for seq_stream_checker. Four instances cover the
// DELAY_CHK=0/1/2 and narrow-width (8-bit data, 4-bit counter) variants.
module tb_seq_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // u0: defaults, DELAY_CHK=0
  logic        rst0, v0, rdy0, err0, pe0;
  logic [31:0] d0, fed0, fee0;
  logic [15:0] rx0, ec0;
  // u2: DELAY_CHK=2
  logic        rst2, v2, rdy2, err2, pe2;
  logic [31:0] d2, fed2, fee2;
  logic [15:0] rx2, ec2;
  // u1: DELAY_CHK=1
  logic        rst1, v1, rdy1, err1, pe1;
  logic [31:0] d1, fed1, fee1;
  logic [15:0] rx1, ec1;
  // u8: 8-bit data, 4-bit counters
  logic        rst8, v8, rdy8, err8, pe8;
  logic [7:0]  d8, fed8, fee8;
  logic [3:0]  rx8, ec8;

  seq_stream_checker u0 (
    .clk(clk), .rst(rst0), .up_valid(v0), .up_data(d0), .up_ready(rdy0),
    .rx_cnt(rx0), .err(err0), .err_cnt(ec0), .first_err_data(fed0),
    .first_err_exp(fee0), .proto_err(pe0)
  );

  seq_stream_checker #(.DELAY_CHK(2)) u2 (
    .clk(clk), .rst(rst2), .up_valid(v2), .up_data(d2), .up_ready(rdy2),
    .rx_cnt(rx2), .err(err2), .err_cnt(ec2), .first_err_data(fed2),
    .first_err_exp(fee2), .proto_err(pe2)
  );

  seq_stream_checker #(.DELAY_CHK(1)) u1 (
    .clk(clk), .rst(rst1), .up_valid(v1), .up_data(d1), .up_ready(rdy1),
    .rx_cnt(rx1), .err(err1), .err_cnt(ec1), .first_err_data(fed1),
    .first_err_exp(fee1), .proto_err(pe1)
  );

  seq_stream_checker #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u8 (
    .clk(clk), .rst(rst8), .up_valid(v8), .up_data(d8), .up_ready(rdy8),
    .rx_cnt(rx8), .err(err8), .err_cnt(ec8), .first_err_data(fed8),
    .first_err_exp(fee8), .proto_err(pe8)
  );

  // One vector = inputs for a cycle plus outputs expected after its edge.
  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] data;
    logic        ready;
    logic [15:0] rx;
    logic        err;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic v, input logic [31:0] d,
                         input logic rdy, input logic [15:0] rx,
                         input logic e, input logic [15:0] ec);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.ready = rdy;
    t.rx = rx; t.err = e; t.ecnt = ec;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; v0 = 1'b0; d0 = '0;
    rst2 = 1'b1; v2 = 1'b0; d2 = '0;
    rst1 = 1'b1; v1 = 1'b0; d1 = '0;
    rst8 = 1'b1; v8 = 1'b0; d8 = '0;

    // ---------------- table: u0, scenarios 1 and 3 ----------------
    add_vec(1, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 1, 0, 0, 0);          // ready rises in 2nd cycle
    for (int i = 0; i < 10; i++)
      add_vec(0, 1, 32'(i), 1, 16'(i + 1), 0, 0);
    add_vec(0, 0, 0, 1, 10, 0, 0);
    add_vec(1, 1, 5, 0, 0, 0, 0);          // beat in reset cycle discarded
    add_vec(0, 0, 0, 1, 0, 0, 0);
    add_vec(0, 1, 0, 1, 1, 0, 0);
    add_vec(0, 1, 1, 1, 2, 0, 0);
    add_vec(0, 1, 2, 1, 3, 0, 0);
    add_vec(0, 1, 7, 1, 4, 1, 1);          // expected 3 -> mismatch
    add_vec(0, 1, 8, 1, 5, 1, 1);
    add_vec(0, 1, 9, 1, 6, 1, 1);
    add_vec(0, 0, 0, 1, 6, 1, 1);

    foreach (vecs[i]) begin
      rst0 = vecs[i].rst;
      v0   = vecs[i].valid;
      d0   = vecs[i].data;
      tick();
      check($sformatf("vec%0d ready", i), rdy0, vecs[i].ready);
      check($sformatf("vec%0d rx_cnt", i), rx0, vecs[i].rx);
      check($sformatf("vec%0d err", i), err0, vecs[i].err);
      check($sformatf("vec%0d err_cnt", i), ec0, vecs[i].ecnt);
    end
    check("s3 first_err_data", fed0, 7);
    check("s3 first_err_exp", fee0, 3);
    check("s3 proto_err", pe0, 0);

    // ---------------- scenario 6: reset mid-stream on u0 ----------------
    rst0 = 1'b1; v0 = 1'b0; tick();
    rst0 = 1'b0; tick();
    v0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d0 = 32'(i + 100);                   // deliberately off-sequence, then reset
      tick();
    end
    rst0 = 1'b1; d0 = 32'd3; tick();
    check("s6 ready in reset", rdy0, 0);
    check("s6 rx after reset", rx0, 0);
    check("s6 err after reset", err0, 0);
    rst0 = 1'b0; d0 = 32'd0; tick();       // ready still low this cycle
    check("s6 rx after release", rx0, 0);
    check("s6 ready second cycle", rdy0, 1);
    tick();
    d0 = 32'd1; tick();
    v0 = 1'b0;
    check("s6 rx_cnt", rx0, 2);
    check("s6 err", err0, 0);
    check("s6 proto_err", pe0, 0);

    // ---------------- scenario 2: u2, DELAY_CHK=2 ----------------
    rst2 = 1'b0; tick();
    check("s2 ready after release", rdy2, 1);
    begin
      int beat = 0;
      v2 = 1'b1;
      for (int c = 0; c < 15; c++) begin
        logic exp_rdy;
        exp_rdy = ((c % 3) == 0);
        d2 = 32'(beat);
        check($sformatf("s2 ready c%0d", c), rdy2, exp_rdy);
        if (exp_rdy) beat++;
        tick();
      end
      v2 = 1'b0;
      check("s2 beats model", 64'(beat), 5);
    end
    check("s2 rx_cnt", rx2, 5);
    check("s2 err", err2, 0);
    check("s2 proto_err", pe2, 0);

    // ---------------- scenario 4: u1, DELAY_CHK=1 ----------------
    rst1 = 1'b0; tick();
    v1 = 1'b1; d1 = 32'd0; tick();         // handshake
    check("s4a ready low", rdy1, 0);
    d1 = 32'd5; tick();                    // stalled beat
    check("s4a no proto yet", pe1, 0);
    check("s4a ready back", rdy1, 1);
    v1 = 1'b0; tick();                     // valid dropped while stalled
    check("s4a proto_err", pe1, 1);
    check("s4a err", err1, 0);
    check("s4a rx_cnt", rx1, 1);
    rst1 = 1'b1; tick();
    check("s4 proto cleared by reset", pe1, 0);
    rst1 = 1'b0; tick();
    v1 = 1'b1; d1 = 32'd0; tick();
    d1 = 32'd5; tick();                    // stalled beat
    d1 = 32'd1; tick();                    // payload changed; matches expected
    v1 = 1'b0;
    check("s4b proto_err", pe1, 1);
    check("s4b err", err1, 0);
    check("s4b rx_cnt", rx1, 2);

    // ---------------- scenario 5: u8, wrap and saturation ----------------
    rst8 = 1'b0; tick();
    v8 = 1'b1;
    for (int i = 0; i < 258; i++) begin    // ..., 254, 255, 0, 1
      d8 = 8'(i);
      tick();
    end
    check("s5 no err at wrap", err8, 0);
    check("s5 err_cnt at wrap", ec8, 0);
    check("s5 rx_cnt wraps", rx8, 2);      // 258 mod 16
    for (int k = 1; k <= 20; k++) begin
      d8 = 8'd100;
      tick();
      check($sformatf("s5 err_cnt k%0d", k), ec8, (k < 15) ? k : 15);
    end
    v8 = 1'b0; tick();
    check("s5 err", err8, 1);
    check("s5 first_err_data", fed8, 100);
    check("s5 first_err_exp", fee8, 2);
    check("s5 rx_cnt", rx8, 6);            // 278 mod 16

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
